uart_fifo_periph: RTL and testbench

- Memory-mapped UART peripheral for the CPU's peripheral bus. Successor to the fixed 8-bit, flag-only UART.
- Adds programmable baud divisor, parametrised data width, TX/RX FIFOs, optional parity and error flags.
- Adds a maskable interrupt.
- Single sysclk domain; the baud tick is derived internally as a clock enable, not a generated clock.

---
 rtl/uart_fifo_periph_pkg.sv | 36 +++
 rtl/uart_fifo_periph_sync_fifo.sv | 49 ++++
 rtl/uart_fifo_periph.sv | 277 +++++++++++++++++++++++++++
 tb/tb_uart_fifo_periph.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_periph_pkg.sv
// Shared definitions for the UART FIFO peripheral: register map, status bit
// positions, control register layout and the serial FSM state encoding.
package uart_fifo_periph_pkg;

  localparam logic [31:0] REG_TXDATA = 32'h0;
  localparam logic [31:0] REG_RXDATA = 32'h4;
  localparam logic [31:0] REG_CON    = 32'h8;
  localparam logic [31:0] REG_DIV    = 32'hC;

  localparam int STAT_TX_BUSY      = 8;
  localparam int STAT_TX_FULL      = 9;
  localparam int STAT_TX_EMPTY     = 10;
  localparam int STAT_RX_EMPTY     = 11;
  localparam int STAT_RX_FULL      = 12;
  localparam int STAT_STICKY_LSB   = 13;  // rx_ovr, frame_err, par_err, tx_ovf
  localparam int STAT_RX_COUNT_LSB = 24;

  // Packed so that tx_en lands on bit 0 of the CON register.
  typedef struct packed {
    logic par_odd;
    logic par_en;
    logic rxne_irq_en;
    logic txe_irq_en;
    logic rx_en;
    logic tx_en;
  } con_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_fifo_periph_sync_fifo.sv
// Single-clock FIFO with a combinational head output; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count define validity.
  always_ff @(posedge sysclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_fifo_periph.sv
// Memory-mapped UART with programmable 16x baud divisor, TX/RX FIFOs,
// optional parity, sticky error flags and a maskable level interrupt.
module uart_fifo_periph
  import uart_fifo_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h40000018,
  parameter int          DATA_BITS   = 8,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd324
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rxd,
  output logic        txd,
  output logic        irqout
);
  localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  logic hit_tx, hit_rx, hit_con, hit_div;
  logic tx_wr, con_wr, div_wr;

  assign hit_tx  = (addr == BASE_ADDR + REG_TXDATA);
  assign hit_rx  = (addr == BASE_ADDR + REG_RXDATA);
  assign hit_con = (addr == BASE_ADDR + REG_CON);
  assign hit_div = (addr == BASE_ADDR + REG_DIV);
  assign tx_wr   = wr && hit_tx;
  assign con_wr  = wr && hit_con;
  assign div_wr  = wr && hit_div;

  con_t        con;
  logic [15:0] div;
  logic [3:0]  sticky;
  logic [3:0]  sticky_set;
  logic [3:0]  sticky_clr;

  logic                 tx_pop, tx_full, tx_empty, tx_busy;
  logic [DATA_BITS-1:0] tx_dout;
  logic [CW-1:0]        tx_count;
  logic                 rx_pop, rx_full, rx_empty;
  logic [DATA_BITS-1:0] rx_dout;
  logic [CW-1:0]        rx_count;

  logic unused_bits;
  assign unused_bits = ^{wdata[31:17], tx_count};

  // ---------------- 16x tick ----------------
  logic [15:0] tick_cnt;
  logic        tick16;

  assign tick16 = (tick_cnt == div);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)                 tick_cnt <= '0;
    else if (div_wr || tick16) tick_cnt <= '0;
    else                       tick_cnt <= tick_cnt + 16'd1;
  end

  // ---------------- receiver ----------------
  logic                 rx_meta, rx_s, rx_prev;
  uart_state_e          rx_state;
  logic [3:0]           rx_cnt, rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_en, rx_par_odd, rx_par_bit;
  logic                 rx_done, rx_ferr_set, rx_perr_set;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx_state    <= ST_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      rx_par_en   <= 1'b0;
      rx_par_odd  <= 1'b0;
      rx_par_bit  <= 1'b0;
      rx_done     <= 1'b0;
      rx_ferr_set <= 1'b0;
      rx_perr_set <= 1'b0;
    end else begin
      rx_done     <= 1'b0;
      rx_ferr_set <= 1'b0;
      rx_perr_set <= 1'b0;
      if (!con.rx_en) begin
        rx_state <= ST_IDLE;
      end else begin
        case (rx_state)
          ST_IDLE: if (rx_prev && !rx_s) begin
            rx_state   <= ST_START;
            rx_cnt     <= '0;
            rx_par_en  <= con.par_en;
            rx_par_odd <= con.par_odd;
          end
          ST_START: if (tick16) begin
            // Mid start bit: a high line here means the fall was a glitch.
            if (rx_cnt == 4'd7) begin
              rx_cnt   <= '0;
              rx_bit   <= '0;
              rx_state <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              rx_cnt <= rx_cnt + 4'd1;
            end
          end
          ST_DATA: if (tick16) begin
            rx_cnt <= rx_cnt + 4'd1;
            if (rx_cnt == 4'd15) begin
              rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
              if (rx_bit == LAST_BIT) rx_state <= rx_par_en ? ST_PARITY : ST_STOP;
              else                    rx_bit   <= rx_bit + 4'd1;
            end
          end
          ST_PARITY: if (tick16) begin
            rx_cnt <= rx_cnt + 4'd1;
            if (rx_cnt == 4'd15) begin
              rx_par_bit <= rx_s;
              rx_state   <= ST_STOP;
            end
          end
          ST_STOP: if (tick16) begin
            rx_cnt <= rx_cnt + 4'd1;
            if (rx_cnt == 4'd15) begin
              rx_state <= ST_IDLE;
              if (!rx_s)
                rx_ferr_set <= 1'b1;
              else if (rx_par_en && (rx_par_bit != ((^rx_shift) ^ rx_par_odd)))
                rx_perr_set <= 1'b1;
              else
                rx_done <= 1'b1;
            end
          end
          default: rx_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx_pop = rd && hit_rx && !rx_empty;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .sysclk (sysclk),
    .reset  (reset),
    .push   (rx_done),
    .pop    (rx_pop),
    .din    (rx_shift),
    .dout   (rx_dout),
    .full   (rx_full),
    .empty  (rx_empty),
    .count  (rx_count)
  );

  // ---------------- transmitter ----------------
  uart_state_e          tx_state;
  logic [3:0]           tx_cnt, tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par_en, tx_par_bit;

  // Frames start on a tick boundary, back to back when the FIFO still has data.
  assign tx_pop  = tick16 && con.tx_en && !tx_empty &&
                   (tx_state == ST_IDLE || (tx_state == ST_STOP && tx_cnt == 4'd15));
  assign tx_busy = (tx_state != ST_IDLE);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      tx_state   <= ST_IDLE;
      txd        <= 1'b1;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx_shift   <= '0;
      tx_par_en  <= 1'b0;
      tx_par_bit <= 1'b0;
    end else if (tx_pop) begin
      tx_state   <= ST_START;
      txd        <= 1'b0;
      tx_cnt     <= '0;
      tx_shift   <= tx_dout;
      tx_par_en  <= con.par_en;
      tx_par_bit <= (^tx_dout) ^ con.par_odd;
    end else if (tick16 && tx_state != ST_IDLE) begin
      tx_cnt <= tx_cnt + 4'd1;
      if (tx_cnt == 4'd15) begin
        case (tx_state)
          ST_START: begin
            tx_state <= ST_DATA;
            tx_bit   <= '0;
            txd      <= tx_shift[0];
          end
          ST_DATA: if (tx_bit == LAST_BIT) begin
            tx_state <= tx_par_en ? ST_PARITY : ST_STOP;
            txd      <= tx_par_en ? tx_par_bit : 1'b1;
          end else begin
            tx_bit   <= tx_bit + 4'd1;
            tx_shift <= tx_shift >> 1;
            txd      <= tx_shift[1];
          end
          ST_PARITY: begin
            tx_state <= ST_STOP;
            txd      <= 1'b1;
          end
          default: begin
            tx_state <= ST_IDLE;
            txd      <= 1'b1;
          end
        endcase
      end
    end
  end

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .sysclk (sysclk),
    .reset  (reset),
    .push   (tx_wr),
    .pop    (tx_pop),
    .din    (wdata[DATA_BITS-1:0]),
    .dout   (tx_dout),
    .full   (tx_full),
    .empty  (tx_empty),
    .count  (tx_count)
  );

  // ---------------- registers ----------------
  assign sticky_clr = con_wr ? wdata[STAT_STICKY_LSB +: 4] : 4'b0;
  assign sticky_set = {tx_wr && tx_full && !tx_pop, rx_perr_set, rx_ferr_set,
                       rx_done && rx_full && !rx_pop};

  // Hardware set is OR-ed in after the clear, so a same-cycle set wins.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      con    <= '0;
      div    <= DEFAULT_DIV;
      sticky <= '0;
    end else begin
      if (con_wr) con <= con_t'(wdata[5:0]);
      if (div_wr) div <= wdata[15:0];
      sticky <= (sticky & ~sticky_clr) | sticky_set;
    end
  end

  logic [31:0] status;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    status                              = '0;
    status[5:0]                         = con;
    status[STAT_TX_BUSY]                = tx_busy;
    status[STAT_TX_FULL]                = tx_full;
    status[STAT_TX_EMPTY]               = tx_empty;
    status[STAT_RX_EMPTY]               = rx_empty;
    status[STAT_RX_FULL]                = rx_full;
    status[STAT_STICKY_LSB +: 4]        = sticky;
    status[STAT_RX_COUNT_LSB +: 8]      = 8'(rx_count);
    rdata = '0;
    if (hit_rx && !rx_empty) rdata = 32'(rx_dout);
    else if (hit_con)        rdata = status;
    else if (hit_div)        rdata = {16'b0, div};
  end

  assign irqout = (con.txe_irq_en && tx_empty && !tx_busy) ||
                  (con.rxne_irq_en && (!rx_empty || (|sticky[2:0])));

endmodule

// File: tb/tb_uart_fifo_periph.sv
// Directed bench: bus reads are scoreboarded (expected pushed at issue, popped
// by a negedge monitor); serial line and irq levels are checked in place.
module tb_uart_fifo_periph;

  localparam logic [31:0] BASE  = 32'h40000018;
  localparam logic [31:0] A_TX  = BASE + 32'h0;
  localparam logic [31:0] A_RX  = BASE + 32'h4;
  localparam logic [31:0] A_CON = BASE + 32'h8;
  localparam logic [31:0] A_DIV = BASE + 32'hC;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic        rxd, txd, irqout;
  logic        loop_en, rxd_drv;

  assign rxd = loop_en ? txd : rxd_drv;
  always #5 sysclk = ~sysclk;

  uart_fifo_periph dut (
    .sysclk (sysclk),
    .reset  (reset),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .rxd    (rxd),
    .txd    (txd),
    .irqout (irqout)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge sysclk) begin : monitor
    exp_t e;
    if (rd) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected read: got 0x%08h, expected no read at %0t", rdata, $time);
      end else begin
        e = exp_q.pop_front();
        check(e.name, rdata, e.exp);
      end
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge sysclk); #1;
    wr = 1'b1; addr = a; wdata = d;
    @(posedge sysclk); #1;
    wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] e, input string name);
    @(posedge sysclk); #1;
    rd = 1'b1; addr = a;
    exp_q.push_back('{name: name, exp: e});
    @(posedge sysclk); #1;
    rd = 1'b0; addr = '0;
  endtask

  // 8N1 frame on rxd with DIV=0 (16 sysclk per bit), then one idle bit time.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int j = 0; j < 10; j++) begin
      @(posedge sysclk); #1 rxd_drv = f[j];
      repeat (15) @(posedge sysclk);
    end
    @(posedge sysclk); #1 rxd_drv = 1'b1;
    repeat (15) @(posedge sysclk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] frame;
    logic [7:0] burst [17];
    int         waited;

    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    rxd_drv = 1'b1; loop_en = 1'b0;
    repeat (3) @(posedge sysclk);
    #1 reset = 1'b0;

    // Reset state
    check("txd after reset", {31'b0, txd}, 32'h1);
    check("irq after reset", {31'b0, irqout}, 32'h0);
    bus_read(A_CON, 32'h00000C00, "con reset");
    bus_read(A_DIV, 32'h00000144, "div reset");
    bus_read(A_TX,  32'h0, "txdata reads zero");
    bus_read(A_RX,  32'h0, "rxdata empty");
    bus_read(BASE + 32'h10, 32'h0, "unmapped read");

    // TX 0x55 with DIV=0: full waveform and busy window
    bus_write(A_DIV, 32'h0);
    bus_read(A_DIV, 32'h0, "div written");
    bus_write(A_CON, 32'h1);
    bus_write(A_TX, 32'h55);
    waited = 0;
    while (txd !== 1'b0 && waited < 64) begin
      @(negedge sysclk);
      waited++;
    end
    check("tx start bit", {31'b0, txd}, 32'h0);
    frame = {1'b1, 8'h55, 1'b0};
    for (int k = 1; k < 170; k++) begin
      @(posedge sysclk); #1;
      rd = 1'b1; addr = A_CON;
      exp_q.push_back('{name: "tx busy window", exp: (k < 160) ? 32'h00000D01 : 32'h00000C01});
      @(negedge sysclk);
      check("txd waveform", {31'b0, txd}, (k < 160) ? 32'(frame[k / 16]) : 32'h1);
    end
    @(posedge sysclk); #1 rd = 1'b0; addr = '0;

    // Loopback, odd parity, 0xA3
    loop_en = 1'b1;
    bus_write(A_CON, 32'h33);
    bus_write(A_TX, 32'hA3);
    repeat (250) @(posedge sysclk);
    bus_read(A_CON, 32'h01000433, "loopback status");
    bus_read(A_RX,  32'h000000A3, "loopback data");
    bus_read(A_CON, 32'h00000C33, "loopback popped");
    loop_en = 1'b0;

    // Framing error, then W1C
    bus_write(A_CON, 32'h2);
    send_frame(8'h3C, 1'b0);
    bus_read(A_CON, 32'h00004C02, "frame_err set");
    bus_write(A_CON, 32'h00004002);
    bus_read(A_CON, 32'h00000C02, "frame_err cleared");

    // FIFO_DEPTH+1 characters without reading
    for (int i = 0; i < 17; i++) begin
      burst[i] = 8'(i * 37 + 5);
      send_frame(burst[i], 1'b1);
    end
    bus_read(A_CON, 32'h10003402, "rx full and overrun");
    for (int i = 0; i < 16; i++) bus_read(A_RX, 32'(burst[i]), "rx burst data");
    bus_read(A_CON, 32'h00002C02, "rx drained ovr sticky");
    bus_write(A_CON, 32'h00002002);
    bus_read(A_CON, 32'h00000C02, "rx_ovr cleared");

    // RX not-empty interrupt
    bus_write(A_CON, 32'h0A);
    check("irq idle rxne", {31'b0, irqout}, 32'h0);
    send_frame(8'h81, 1'b1);
    check("irq after push", {31'b0, irqout}, 32'h1);
    send_frame(8'h7E, 1'b1);
    bus_read(A_RX, 32'h00000081, "irq rx first");
    check("irq one left", {31'b0, irqout}, 32'h1);
    bus_read(A_RX, 32'h0000007E, "irq rx last");
    check("irq after last pop", {31'b0, irqout}, 32'h0);

    // 4-tick glitch: false start
    @(posedge sysclk); #1 rxd_drv = 1'b0;
    repeat (4) @(posedge sysclk);
    #1 rxd_drv = 1'b1;
    repeat (40) @(posedge sysclk);
    check("irq after glitch", {31'b0, irqout}, 32'h0);
    bus_read(A_CON, 32'h00000C0A, "glitch no push no error");

    // TX-empty interrupt
    bus_write(A_CON, 32'h04);
    #2 check("txe irq", {31'b0, irqout}, 32'h1);
    bus_write(A_CON, 32'h0);
    #2 check("irq masked", {31'b0, irqout}, 32'h0);

    // TX FIFO overflow with transmitter disabled
    for (int i = 0; i < 17; i++) bus_write(A_TX, 32'(i));
    bus_read(A_CON, 32'h00010A00, "tx full and ovf");
    check("txd idle while disabled", {31'b0, txd}, 32'h1);

    repeat (2) @(posedge sysclk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
